gamepad_pmod_tx: RTL and testbench

Serializer for the Gamepad Pmod wire protocol. It drives pmod_data, pmod_clk and pmod_latch from a parallel button word, so that gamepad_pmod_single or gamepad_pmod_dual reconstructs that word exactly. Used as a controller emulator for on-chip loopback tests, and as the source side when a design must present gamepad state to another Pmod-gamepad consumer.

---
 rtl/gamepad_pmod_pkg.sv | 36 +++
 rtl/gamepad_pmod_tx_timer.sv | 40 ++++
 rtl/gamepad_pmod_tx.sv | 156 +++++++++++++++
 tb/tb_gamepad_pmod_tx.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/gamepad_pmod_pkg.sv
// Shared types and constants for the Gamepad Pmod transmitter and its timer.
package gamepad_pmod_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SHIFT_LO,
        SHIFT_HI,
        LATCH,
        GAP
    } state_t;

    localparam int B_IDX      = 11;
    localparam int Y_IDX      = 10;
    localparam int SELECT_IDX = 9;
    localparam int START_IDX  = 8;
    localparam int UP_IDX     = 7;
    localparam int DOWN_IDX   = 6;
    localparam int LEFT_IDX   = 5;
    localparam int RIGHT_IDX  = 4;
    localparam int A_IDX      = 3;
    localparam int X_IDX      = 2;
    localparam int L_IDX      = 1;
    localparam int R_IDX      = 0;

    localparam int SINGLE_WIDTH = 12;
    localparam int DUAL_WIDTH   = 24;

    localparam logic [11:0] ABSENT_WORD = 12'hFFF;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/gamepad_pmod_tx_timer.sv
// Loadable phase down-counter; last_o is high on the final cycle of a loaded phase.
module gamepad_pmod_tx_timer #(
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic [CNT_W-1:0] value_i,
    output logic             last_o,
    output logic             last_nxt_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             last_q;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = value_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Lookahead lets the parent register pulses that must coincide with a phase's last cycle.
    assign last_nxt_o = (cnt_d == CNT_W'(1));

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q  <= '0;
            last_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            last_q <= last_nxt_o;
        end
    end

    assign last_o = last_q;

endmodule

// File: rtl/gamepad_pmod_tx.sv
// Gamepad Pmod serializer: parallel button word in, pmod_data/clk/latch out.
// Define GAMEPAD_PMOD_TX_AUTO_EN for free-running back-to-back frames without handshake.
module gamepad_pmod_tx
    import gamepad_pmod_pkg::*;
#(
    parameter int BIT_WIDTH  = 12,
    parameter int CLK_DIV    = 4,
    parameter int GAP_CYCLES = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [BIT_WIDTH-1:0]    buttons,
    input  logic [BIT_WIDTH/12-1:0] present,
    input  logic                    btn_valid,
    output logic                    btn_ready,
    output logic                    pmod_data,
    output logic                    pmod_clk,
    output logic                    pmod_latch,
    output logic                    busy,
    output logic                    frame_done
);

    localparam int NUM_CTRL = BIT_WIDTH / SINGLE_WIDTH;
    localparam int CNT_W    = $clog2(max3(CLK_DIV, GAP_CYCLES, BIT_WIDTH) + 1);

    if (CLK_DIV < 4) begin : g_bad_clk_div
        $error("gamepad_pmod_tx: CLK_DIV must be at least 4");
    end
    if (BIT_WIDTH % SINGLE_WIDTH != 0 || NUM_CTRL < 1) begin : g_bad_width
        $error("gamepad_pmod_tx: BIT_WIDTH must be a multiple of 12");
    end

    state_t               state_q, state_d;
    logic [BIT_WIDTH-1:0] shreg_q, shreg_d, capture;
    logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic                 start, tc, tc_nxt, tmr_load;
    logic [CNT_W-1:0]     tmr_value;

    logic data_q, data_d, pclk_q, pclk_d, latch_q, latch_d;
    logic busy_q, busy_d, done_q, done_d, ready_q, ready_d;

`ifdef GAMEPAD_PMOD_TX_AUTO_EN
    localparam logic READY_IDLE = 1'b0;
    assign start = (state_q == IDLE);
`else
    localparam logic READY_IDLE = 1'b1;
    assign start = (state_q == IDLE) && btn_valid;
`endif

    always_comb begin
        capture = '0;
        for (int i = 0; i < NUM_CTRL; i++) begin
            capture[i*SINGLE_WIDTH +: SINGLE_WIDTH] =
                present[i] ? buttons[i*SINGLE_WIDTH +: SINGLE_WIDTH] : ABSENT_WORD;
        end
    end

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        case (state_q)
            IDLE: begin
                shreg_d   = '0;
                bit_cnt_d = '0;
                if (start) begin
                    shreg_d   = capture;
                    bit_cnt_d = CNT_W'(BIT_WIDTH);
                    state_d   = SHIFT_LO;
                end
            end
            SHIFT_LO: if (tc) state_d = SHIFT_HI;
            SHIFT_HI: begin
                if (tc) begin
                    shreg_d   = shreg_q << 1;
                    bit_cnt_d = bit_cnt_q - 1'b1;
                    state_d   = (bit_cnt_q == CNT_W'(1)) ? LATCH : SHIFT_LO;
                end
            end
            LATCH: if (tc) state_d = (GAP_CYCLES == 0) ? IDLE : GAP;
            GAP:   if (tc) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Every state entry reloads the timer; IDLE keeps it parked at zero.
    always_comb begin
        tmr_load  = (state_d != state_q) || (state_q == IDLE);
        tmr_value = '0;
        case (state_d)
            SHIFT_LO, SHIFT_HI, LATCH: tmr_value = CNT_W'(CLK_DIV);
            GAP:                       tmr_value = CNT_W'(GAP_CYCLES);
            default:                   tmr_value = '0;
        endcase
    end

    gamepad_pmod_tx_timer #(.CNT_W(CNT_W)) u_timer (
        .clk        (clk),
        .reset      (reset),
        .load_i     (tmr_load),
        .value_i    (tmr_value),
        .last_o     (tc),
        .last_nxt_o (tc_nxt)
    );

    // Outputs are decoded from the next state so every pin comes straight from a flop.
    always_comb begin
        data_d  = 1'b0;
        pclk_d  = 1'b0;
        latch_d = 1'b0;
        busy_d  = (state_d != IDLE);
        ready_d = (state_d == IDLE) ? READY_IDLE : 1'b0;
        done_d  = tc_nxt && ((state_d == GAP) || (GAP_CYCLES == 0 && state_d == LATCH));
        case (state_d)
            SHIFT_LO: data_d = shreg_d[BIT_WIDTH-1];
            SHIFT_HI: begin
                data_d = shreg_d[BIT_WIDTH-1];
                pclk_d = 1'b1;
            end
            LATCH:   latch_d = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            shreg_q   <= '0;
            bit_cnt_q <= '0;
            data_q    <= 1'b0;
            pclk_q    <= 1'b0;
            latch_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            ready_q   <= READY_IDLE;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            bit_cnt_q <= bit_cnt_d;
            data_q    <= data_d;
            pclk_q    <= pclk_d;
            latch_q   <= latch_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            ready_q   <= ready_d;
        end
    end

    assign btn_ready  = ready_q;
    assign pmod_data  = data_q;
    assign pmod_clk   = pclk_q;
    assign pmod_latch = latch_q;
    assign busy       = busy_q;
    assign frame_done = done_q;

endmodule

// File: tb/tb_gamepad_pmod_tx.sv
// Directed bench: single-controller instance at defaults plus a dual instance with no gap.
module tb_gamepad_pmod_tx;
    import gamepad_pmod_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [11:0] buttons;
    logic [0:0]  present;
    logic        btn_valid;
    logic        btn_ready, pmod_data, pmod_clk, pmod_latch, busy, frame_done;

    logic [23:0] buttons2;
    logic [1:0]  present2;
    logic        btn_valid2;
    logic        btn_ready2, pmod_data2, pmod_clk2, pmod_latch2, busy2, frame_done2;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    gamepad_pmod_tx #(.BIT_WIDTH(12), .CLK_DIV(4), .GAP_CYCLES(8)) dut (
        .clk(clk), .reset(reset), .buttons(buttons), .present(present),
        .btn_valid(btn_valid), .btn_ready(btn_ready), .pmod_data(pmod_data),
        .pmod_clk(pmod_clk), .pmod_latch(pmod_latch), .busy(busy),
        .frame_done(frame_done)
    );

    gamepad_pmod_tx #(.BIT_WIDTH(24), .CLK_DIV(4), .GAP_CYCLES(0)) dut2 (
        .clk(clk), .reset(reset), .buttons(buttons2), .present(present2),
        .btn_valid(btn_valid2), .btn_ready(btn_ready2), .pmod_data(pmod_data2),
        .pmod_clk(pmod_clk2), .pmod_latch(pmod_latch2), .busy(busy2),
        .frame_done(frame_done2)
    );

    // Receiver model: shift on pmod_clk rise, commit on pmod_latch rise.
    logic        pc_prev = 1'b0, pl_prev = 1'b0, pd_prev = 1'b0;
    logic [11:0] rx_sh = '0, rx_word = '0;
    int          edge_cnt = 0, rx_edges = 0, stab_viol = 0;

    always @(posedge clk) begin
        pc_prev <= pmod_clk;
        pl_prev <= pmod_latch;
        pd_prev <= pmod_data;
        if (pmod_clk && !pc_prev) begin
            rx_sh    <= {rx_sh[10:0], pmod_data};
            edge_cnt <= edge_cnt + 1;
        end
        if (pmod_latch && !pl_prev) begin
            rx_word  <= rx_sh;
            rx_edges <= edge_cnt;
            edge_cnt <= 0;
        end
        if (pmod_clk && (pmod_data != pd_prev)) stab_viol <= stab_viol + 1;
        if (reset) edge_cnt <= 0;
    end

    logic        pc2_prev = 1'b0, pl2_prev = 1'b0;
    logic [23:0] rx2_sh = '0, rx2_word = '0;

    always @(posedge clk) begin
        pc2_prev <= pmod_clk2;
        pl2_prev <= pmod_latch2;
        if (pmod_clk2 && !pc2_prev) rx2_sh <= {rx2_sh[22:0], pmod_data2};
        if (pmod_latch2 && !pl2_prev) rx2_word <= rx2_sh;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [23:0] obs, input logic [23:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called while observing cycle 1 after a handshake; returns the cycle index of frame_done.
    task automatic wait_done(input bit dual, output int cyc);
        cyc = 1;
        while (!(dual ? frame_done2 : frame_done) && cyc < 500) begin
            step();
            cyc++;
        end
    endtask

    int          cyc, nhs, fd_seen;
    logic [11:0] exp_hs [2];
    logic [11:0] prev_word;

    initial begin
        reset = 1'b1; btn_valid = 1'b0; buttons = '0; present = 1'b1;
        btn_valid2 = 1'b0; buttons2 = '0; present2 = 2'b11;
        repeat (3) step();
        check("reset_outs", {btn_ready, busy, pmod_data, pmod_clk, pmod_latch, frame_done}, 6'b100000);
        check("reset_outs2", {btn_ready2, busy2, pmod_data2, pmod_clk2, pmod_latch2, frame_done2}, 6'b100000);
        reset = 1'b0;
        step();
        check("idle_ready", {btn_ready, busy}, 2'b10);

        // Single frame at defaults; buttons changed after the handshake must not matter.
        buttons = 12'hA05; present = 1'b1; btn_valid = 1'b1;
        step();
        btn_valid = 1'b0; buttons = 12'h7FF;
        check("t1_first_cycle", {btn_ready, busy, pmod_data, pmod_clk}, 4'b0110);
        wait_done(1'b0, cyc);
        check("t1_length", cyc, 108);
        check("t1_word", rx_word, 12'hA05);
        check("t1_edges", rx_edges, 12);
        check("t1_b", rx_word[B_IDX], 1'b1);
        check("t1_select", rx_word[SELECT_IDX], 1'b1);
        check("t1_x", rx_word[X_IDX], 1'b1);
        check("t1_r", rx_word[R_IDX], 1'b1);
        check("t1_dpad", rx_word[UP_IDX:RIGHT_IDX], 4'h0);
        step();
        check("t1_back_idle", {btn_ready, busy, frame_done}, 3'b100);

        // Absent controller sends all ones.
        buttons = 12'h000; present = 1'b0; btn_valid = 1'b1;
        step();
        btn_valid = 1'b0; present = 1'b1;
        wait_done(1'b0, cyc);
        check("t2_word", rx_word, 12'hFFF);
        check("t2_edges", rx_edges, 12);
        step();

        // Dual, zero-length gap: frame_done lands on the last latch cycle.
        buttons2 = 24'h800001; present2 = 2'b11; btn_valid2 = 1'b1;
        step();
        btn_valid2 = 1'b0;
        wait_done(1'b1, cyc);
        check("t3_length", cyc, 196);
        check("t3_word", rx2_word, 24'h800001);
        check("t3_ctrl1_b", rx2_word[12 + B_IDX], 1'b1);
        check("t3_ctrl0_r", rx2_word[R_IDX], 1'b1);
        step();
        check("t3_back_idle", {btn_ready2, busy2, frame_done2}, 3'b100);
        present2 = 2'b01; btn_valid2 = 1'b1;
        step();
        btn_valid2 = 1'b0;
        wait_done(1'b1, cyc);
        check("t3_absent_ctrl1", rx2_word, 24'hFFF001);
        step();

        // Valid held high with a changing word: handshakes only in IDLE.
        nhs = 0; fd_seen = 0;
        exp_hs[0] = '0; exp_hs[1] = '0;
        for (int i = 0; i < 200; i++) begin
            buttons   = 12'((i * 37 + 5) % 4096);
            btn_valid = 1'b1;
            if (btn_ready) begin
                if (nhs < 2) exp_hs[nhs] = buttons;
                nhs++;
            end
            step();
            if (frame_done) begin
                check("t4_frame0_word", rx_word, exp_hs[0]);
                fd_seen++;
            end
        end
        btn_valid = 1'b0;
        check("t4_handshakes", nhs, 2);
        check("t4_frames_in_window", fd_seen, 1);
        cyc = 0;
        while (!frame_done && cyc < 300) begin
            step();
            cyc++;
        end
        check("t4_frame1_seen", frame_done, 1'b1);
        check("t4_frame1_word", rx_word, exp_hs[1]);
        step();

        // Reset during SHIFT_HI of bit 5 (cycles 37..40 after the handshake).
        prev_word = rx_word;
        buttons = 12'h3C3; btn_valid = 1'b1;
        step();
        btn_valid = 1'b0;
        repeat (37) step();
        check("t5_in_shift_hi", {busy, pmod_clk}, 2'b11);
        reset = 1'b1;
        step();
        check("t5_reset_outs", {btn_ready, busy, pmod_data, pmod_clk, pmod_latch, frame_done}, 6'b100000);
        reset = 1'b0;
        repeat (150) step();
        check("t5_rx_kept", rx_word, prev_word);
        check("t5_still_idle", {btn_ready, busy}, 2'b10);

        buttons = 12'h5A5; btn_valid = 1'b1;
        step();
        btn_valid = 1'b0;
        wait_done(1'b0, cyc);
        check("t5_after_reset_len", cyc, 108);
        check("t5_after_reset_word", rx_word, 12'h5A5);
        check("t5_after_reset_edges", rx_edges, 12);
        step();

        check("data_stable_while_clk_high", stab_viol, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
